// File: rtl/spell_stack_unit.sv
// Stack with single-cycle pop/push of up to two entries, a sequenced clear and a debug shift register.
// Define SPELL_STACK_GUARD_EN to add fill-level tracking with sticky ovf/unf flags instead of silent wrap.
module spell_stack_unit #(
    parameter  int DEPTH = 32,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_en,
    input  logic [1:0]       op_pop,
    input  logic [1:0]       op_push,
    input  logic [WIDTH-1:0] op_top,
    input  logic [WIDTH-1:0] op_below,
    input  logic             clr,
    output logic             busy,
    output logic [PTR_W-1:0] sp,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] below,
    input  logic             dbg_shift_in,
    input  logic             dbg_load,
    input  logic             dbg_dump,
    output logic             dbg_shift_out,
    output logic             ovf,
    output logic             unf,
    input  logic             err_clr
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [PTR_W-1:0] clr_idx_q, clr_idx_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             shift_out_q, shift_out_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             wr0_en, wr1_en;
    logic [PTR_W-1:0] wr0_addr, wr1_addr;
    logic [WIDTH-1:0] wr0_data, wr1_data;
    logic [1:0]       pop_n, push_n;
    logic [PTR_W-1:0] op_sp;
    logic             clr_go, op_go, ld_go;
    logic             op_unf, op_ovf, ld_ovf;

    assign pop_n  = (op_pop == 2'd3) ? 2'd2 : op_pop;
    assign push_n = (op_push == 2'd3) ? 2'd2 : op_push;
    assign op_sp  = sp_q - PTR_W'(pop_n) + PTR_W'(push_n);

    // clr beats op_en, which beats dbg_load; nothing is accepted while clearing
    assign clr_go = (state_q == IDLE) && clr;
    assign op_go  = (state_q == IDLE) && !clr && op_en;
    assign ld_go  = (state_q == IDLE) && !clr && !op_en && dbg_load;

    assign top           = mem_q[sp_q - PTR_W'(1)];
    assign below         = mem_q[sp_q - PTR_W'(2)];
    assign sp            = sp_q;
    assign busy          = (state_q == CLEAR);
    assign dbg_shift_out = shift_out_q;

`ifdef SPELL_STACK_GUARD_EN
    logic [PTR_W:0]   level_q, level_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [PTR_W+1:0] op_level;
    logic [PTR_W:0]   ld_level;

    // Level fits in PTR_W+1 bits; the extra top bit of op_level flags a negative result
    assign op_level = {2'b00, level_q} + (PTR_W+2)'(push_n) - (PTR_W+2)'(pop_n);
    assign ld_level = level_q + (PTR_W+1)'(1);
    assign op_unf   = op_level[PTR_W+1];
    assign op_ovf   = !op_level[PTR_W+1] && (op_level > (PTR_W+2)'(DEPTH));
    assign ld_ovf   = ld_level > (PTR_W+1)'(DEPTH);

    always_comb begin
        level_d = level_q;
        ovf_d   = ovf_q & ~err_clr;
        unf_d   = unf_q & ~err_clr;
        if (clr_go) begin
            level_d = '0;
        end else if (op_go) begin
            if (op_unf)      unf_d   = 1'b1;
            else if (op_ovf) ovf_d   = 1'b1;
            else             level_d = op_level[PTR_W:0];
        end else if (ld_go) begin
            if (ld_ovf) ovf_d   = 1'b1;
            else        level_d = ld_level;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign op_unf         = 1'b0;
    assign op_ovf         = 1'b0;
    assign ld_ovf         = 1'b0;
    assign ovf            = 1'b0;
    assign unf            = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        clr_idx_d   = clr_idx_q;
        sr_d        = dbg_dump ? top : {sr_q[WIDTH-2:0], dbg_shift_in};
        shift_out_d = sr_q[WIDTH-1];
        wr0_en      = 1'b0;
        wr0_addr    = sp_q;
        wr0_data    = '0;
        wr1_en      = 1'b0;
        wr1_addr    = sp_q;
        wr1_data    = '0;
        case (state_q)
            IDLE: begin
                if (clr_go) begin
                    state_d   = CLEAR;
                    sp_d      = '0;
                    clr_idx_d = '0;
                end else if (op_go && !op_unf && !op_ovf) begin
                    sp_d     = op_sp;
                    wr0_en   = (push_n != 2'd0);
                    wr0_addr = op_sp - PTR_W'(1);
                    wr0_data = op_top;
                    wr1_en   = (push_n == 2'd2);
                    wr1_addr = op_sp - PTR_W'(2);
                    wr1_data = op_below;
                end else if (ld_go && !ld_ovf) begin
                    sp_d     = sp_q + PTR_W'(1);
                    wr0_en   = 1'b1;
                    wr0_addr = sp_q;
                    wr0_data = sr_q;
                end
            end
            CLEAR: begin
                sp_d      = '0;
                wr0_en    = 1'b1;
                wr0_addr  = clr_idx_q;
                clr_idx_d = clr_idx_q + PTR_W'(1);
                if (clr_idx_q == PTR_W'(DEPTH - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sp_q        <= '0;
            clr_idx_q   <= '0;
            sr_q        <= '0;
            shift_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            clr_idx_q   <= clr_idx_d;
            sr_q        <= sr_d;
            shift_out_q <= shift_out_d;
        end
    end

    // Storage is never reset; a reset cycle only suppresses the pending write
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr0_en) mem_q[wr0_addr] <= wr0_data;
            if (wr1_en) mem_q[wr1_addr] <= wr1_data;
        end
    end

endmodule

// File: doc/spell_stack_unit.md
SPELL_STACK_UNIT -- requirements
Module: spell_stack_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of stack entries; must be a power of two and at least 4.
REQ-002 SHALL have parameter WIDTH, default 8, meaning bits per entry and width of the debug shift register.
REQ-003 SHALL derive local PTR_W = clog2(DEPTH).
REQ-004 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: op_en  in  1  apply stack update; op_pop  in  2  entries removed (0..2); op_push  in  2  entries written (0..2).
REQ-006 SHALL have ports: op_top  in  WIDTH  new top value; op_below  in  WIDTH  new below-top value.
REQ-007 SHALL have ports: clr  in  1  start clear sequence; busy  out  1  clear in progress; sp  out  PTR_W  stack pointer.
REQ-008 SHALL have ports: top  out  WIDTH  entry sp-1; below  out  WIDTH  entry sp-2.
REQ-009 SHALL have ports: dbg_shift_in  in  1  serial in; dbg_load  in  1  push shift register; dbg_dump  in  1  capture top; dbg_shift_out  out  1  serial out.
REQ-010 SHALL have ports: ovf  out  1  sticky overflow; unf  out  1  sticky underflow; err_clr  in  1  clear ovf/unf.

Function
REQ-011 SHALL drive top = mem[sp-1] and below = mem[sp-2] combinationally, with indices taken modulo DEPTH.
REQ-012 On op_en with busy=0, SHALL set sp <= sp - op_pop + op_push modulo DEPTH at the next edge; op_pop=3 or op_push=3 is treated as 2.
REQ-013 When op_push is 1 or 2, SHALL write op_top to mem[next_sp-1]; when op_push is 2, SHALL also write op_below to mem[next_sp-2], in the same cycle.
REQ-014 SHALL implement an FSM with states IDLE and CLEAR; a clr pulse in IDLE enters CLEAR.
REQ-015 In CLEAR, SHALL write 0 to entries 0..DEPTH-1, one per cycle in ascending order, with sp held at 0 and busy=1; after entry DEPTH-1 it returns to IDLE, giving exactly DEPTH busy cycles.
REQ-016 SHALL ignore op_en, dbg_load and clr while busy=1.
REQ-017 SHALL shift the debug register every cycle: sr <= {sr[WIDTH-2:0], dbg_shift_in}; dbg_shift_out <= sr[WIDTH-1], registered.
REQ-018 dbg_dump SHALL load sr <= top instead of shifting that cycle.
REQ-019 dbg_load SHALL write mem[sp] <= sr and set sp <= sp+1, using the pre-shift sr value.
REQ-020 If op_en and dbg_load are asserted together, op_en SHALL win and dbg_load SHALL be dropped; dbg_dump is independent of both.
REQ-021 Pointer arithmetic SHALL wrap silently modulo DEPTH unless the guard feature (REQ-026) is enabled.

Reset
REQ-022 On rst_n=0 at a clk edge, SHALL set sp=0, sr=0, dbg_shift_out=0, busy=0, ovf=0, unf=0 and FSM state IDLE.
REQ-023 SHALL NOT clear storage contents on reset; clearing is done only by the clr sequence.
REQ-024 Reset asserted during CLEAR SHALL abort the sequence immediately, leaving the remaining entries unchanged.
REQ-025 SHALL ignore all inputs during reset.

Configuration
REQ-026 With macro SPELL_STACK_GUARD_EN defined, SHALL track a fill level 0..DEPTH (PTR_W+1 bits); an op or load that would drop the level below 0 SHALL be suppressed (no write, sp unchanged) and set unf; one that would raise it above DEPTH SHALL be suppressed and set ovf.
REQ-027 With SPELL_STACK_GUARD_EN defined, ovf and unf SHALL stay set until err_clr; if err_clr coincides with a new error, the error wins.
REQ-028 Without SPELL_STACK_GUARD_EN, ovf and unf SHALL be constant 0, err_clr SHALL be unused, and wrap-around per REQ-021 applies.

Verification (DEPTH=32, WIDTH=8)
REQ-029 Push 0x11 then 0x22 (op_push=1 each) -> sp=2, top=0x22, below=0x11; then op_pop=2, op_push=1, op_top=0x33 -> sp=1, top=0x33.
REQ-030 Shift in 0xA5 MSB-first over 8 cycles, then pulse dbg_load -> sp+1 and top=0xA5; pulse dbg_dump, then shift 8 cycles -> 0xA5 is seen MSB-first on dbg_shift_out, 1 cycle late.
REQ-031 Pulse clr with sp=5 -> busy for exactly 32 cycles, sp=0, all entries 0; an op_en during busy causes no change.
REQ-032 Guard build: op_pop=1 at sp=0 -> unf=1, sp=0; 32 pushes then 1 more -> ovf=1, sp stays 0 (wrapped), level 32; err_clr -> flags clear.
REQ-033 Non-guard build: op_pop=1 at sp=0 -> sp=31, ovf=unf=0; rst_n low at clear step 10 -> busy=0, entries 10..31 keep old values.
